fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter: RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: stall  in  1  hold PC and IF/ID register.
REQ-006 Port: flush  in  1  squash IF/ID contents to a bubble.
REQ-007 Port: branch_taken  in  1  redirect PC to branch_target.
REQ-008 Port: branch_target  in  32  byte address of the branch destination.
REQ-009 Port: jump  in  1  redirect PC to jump_target.
REQ-010 Port: jump_target  in  32  byte address of the jump destination.
REQ-011 Port: imem_a  out  6  word index to instruction memory.
REQ-012 Port: imem_rd  in  32  instruction word returned combinationally by instruction memory.
REQ-013 Port: instr  out  32  IF/ID instruction.
REQ-014 Port: pc_id  out  32  byte address of instr.
REQ-015 Port: pc_plus4  out  32  pc_id + 4.
REQ-016 Port: valid  out  1  instr is a real fetched instruction, not a bubble.
REQ-017 Port: fetch_count  out  32  number of instructions accepted into IF/ID.

Function
REQ-018 Internal 32-bit PC register; imem_a SHALL equal pc[7:2] combinationally, and the instruction word index SHALL wrap modulo 64 words.
REQ-019 The next PC SHALL be chosen by priority: jump -> {jump_target[31:2],2'b00}; else branch_taken -> {branch_target[31:2],2'b00}; else stall -> hold; else pc+4.
REQ-020 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-021 On a normal cycle (no stall, redirect or flush), the IF/ID register SHALL capture instr<=imem_rd, pc_id<=pc, pc_plus4<=pc+4, valid<=1, and fetch_count SHALL increment.
REQ-022 When jump or branch_taken is asserted, the IF/ID register SHALL load a bubble (instr=0, valid=0; pc_id and pc_plus4 hold) and fetch_count SHALL hold.
REQ-023 flush SHALL load a bubble into IF/ID; the PC SHALL still update per REQ-019, and fetch_count SHALL hold.
REQ-024 stall alone SHALL hold the PC and all IF/ID outputs and fetch_count unchanged.
REQ-025 stall together with a redirect: the redirect SHALL win; the PC SHALL load the target and IF/ID SHALL load a bubble.
REQ-026 stall together with flush (no redirect): the PC SHALL hold and IF/ID SHALL load a bubble.
REQ-027 jump and branch_taken together: jump SHALL win.
REQ-028 Fetch latency SHALL be one cycle: an instruction at the PC in cycle N SHALL appear on instr after the clk edge ending cycle N.
REQ-029 fetch_count SHALL wrap modulo 2^32.
REQ-030 The low two bits of the targets SHALL be ignored; the PC SHALL always be word-aligned.

Reset
REQ-031 Asserting reset SHALL immediately, without waiting for clk, set pc=RESET_PC, instr=0, pc_id=0, pc_plus4=0, valid=0 and fetch_count=0.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL override all other inputs.
REQ-033 On the first clk edge after reset deasserts, the block SHALL fetch from RESET_PC.

Verification
REQ-034 Sequential fetch: imem word k=k+1, release reset, 4 edges -> instr = 1,2,3,4; pc_id = 0,4,8,C; valid=1; fetch_count=4.
REQ-035 Branch: branch_taken=1 and branch_target=32'h00000043 for one cycle at pc=8 -> next instr is a bubble (instr=0, valid=0); the following instr is word 16 with pc_id=0x40.
REQ-036 Stall/flush: stall=1 for 3 cycles at pc=0x10 -> instr and pc_id frozen; stall+flush -> valid=0 and pc held at 0x10.
REQ-037 Priority and wrap: jump=1 (target 0x0C) with branch_taken=1 (target 0x20) -> PC=0x0C; PC at 0xFC then advance -> imem_a=0, pc=0x100.
REQ-038 Asynchronous reset mid-run: assert reset between edges with fetch_count=7 -> all outputs cleared before the next edge, and pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a 32-bit PC and an IF/ID pipeline register.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   stall             hold PC and IF/ID contents
//   flush             squash IF/ID to a bubble (PC still advances unless stalled)
//   branch_taken      redirect PC to branch_target (word-aligned)
//   jump              redirect PC to jump_target (word-aligned), wins over branch_taken
//   imem_a            word index into a 64-word instruction memory (pc[7:2])
//   imem_rd           instruction word read combinationally from imem_a
//   instr, pc_id      IF/ID instruction and its byte address
//   pc_plus4          pc_id + 4
//   valid             instr is a real fetched instruction, not a bubble
//   fetch_count       number of instructions accepted into IF/ID (wraps modulo 2^32)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [5:0]  imem_a,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_inc;
  logic        redirect;

  // Target byte-offset bits are deliberately dropped to keep the PC word-aligned.
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^{jump_target[1:0], branch_target[1:0]};

  assign pc_inc   = pc_q + 32'd4;
  assign redirect = jump | branch_taken;
  assign imem_a   = pc_q[7:2];

  always_comb begin
    pc_d = pc_inc;
    if (jump) begin
      pc_d = {jump_target[31:2], 2'b00};
    end else if (branch_taken) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // Redirect and flush both squash the stage; stall alone freezes it.
  always_comb begin
    instr_d       = instr_q;
    pc_id_d       = pc_id_q;
    pc_plus4_d    = pc_plus4_q;
    valid_d       = valid_q;
    fetch_count_d = fetch_count_q;
    if (redirect || flush) begin
      instr_d = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d       = imem_rd;
      pc_id_d       = pc_q;
      pc_plus4_d    = pc_inc;
      valid_d       = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      pc_id_q       <= 32'd0;
      pc_plus4_q    <= 32'd0;
      valid_q       <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_id_q       <= pc_id_d;
      pc_plus4_q    <= pc_plus4_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign instr       = instr_q;
  assign pc_id       = pc_id_q;
  assign pc_plus4    = pc_plus4_q;
  assign valid       = valid_q;
  assign fetch_count = fetch_count_q;

endmodule
